// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC link codes, response field layout and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam logic [3:0] CODE_IDLE           = 4'b1_000;
  localparam logic [3:0] CODE_READ           = 4'b1_001;
  localparam logic [3:0] CODE_READ_RESPONSE  = 4'b1_010;
  localparam logic [3:0] CODE_WRITE          = 4'b1_011;
  localparam logic [3:0] CODE_WRITE_RESPONSE = 4'b1_100;
  localparam logic [3:0] CODE_RESERVED       = 4'b1_101;
  localparam logic [3:0] CODE_MESSAGE        = 4'b1_110;
  localparam logic [3:0] CODE_END            = 4'b1_111;

  localparam int RSP_RSVD_BIT = 4;
  localparam int RSP_ERR_BIT  = 3;

  localparam logic [8:0] LINK_IDLE = 9'h100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_RID  = 2'd2,
    S_DATA = 2'd3
  } state_e;

  // Header link word {ALE, byte}; the code field is only meaningful with err set.
  function automatic logic [8:0] rsp_hdr(input logic is_write, input logic err,
                                         input logic [2:0] code);
    logic [3:0] main;
    logic [7:0] b;
    main              = is_write ? CODE_WRITE_RESPONSE : CODE_READ_RESPONSE;
    b                 = '0;
    b[7:5]            = main[2:0];
    b[RSP_RSVD_BIT]   = 1'b0;
    b[RSP_ERR_BIT]    = err;
    b[2:0]            = err ? code : 3'b000;
    return {main[3], b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_resp_fifo
// Description : First-word-fall-through completion queue, synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/noc_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : noc_resp_serializer
// Description : Queues read/write completions and serializes response packets.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_resp_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_write,
  input  logic [7:0]              req_src_id,
  input  logic                    req_err,
  input  logic [2:0]              req_err_code,
  input  logic [8*DATA_BYTES-1:0] req_rd_data,
  output logic [7:0]              CMD_WRITE,
  output logic                    ALE_WRITE,
  output logic                    busy
);
  import noc_pkg::*;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int PKT_W  = 1 + 8 + 1 + 3 + DATA_W;
  localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);

  typedef struct packed {
    logic              is_write;
    logic [7:0]        src_id;
    logic              err;
    logic [2:0]        code;
    logic [DATA_W-1:0] data;
  } pkt_t;

  pkt_t             fifo_din;
  pkt_t             fifo_dout;
  pkt_t             pkt_q, pkt_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       link_q, link_d;
  logic             pkt_end;
  logic             rd_ok;

  assign req_ready = ~fifo_full & ~rst;
  assign fifo_din  = {req_is_write, req_src_id, req_err, req_err_code, req_rd_data};

  noc_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid & req_ready),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      cnt_q   <= '0;
      link_q  <= LINK_IDLE;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      link_q  <= link_d;
    end
  end

  assign rd_ok = ~pkt_q.is_write & ~pkt_q.err;

  // Idle behaves like a finished packet so the next head starts with no gap.
  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    pkt_end  = 1'b0;
    case (state_q)
      S_IDLE: pkt_end = 1'b1;
      S_HDR:  state_d = S_RID;
      S_RID: begin
        if (rd_ok) begin
          state_d = S_DATA;
          cnt_d   = LAST_BYTE;
        end else begin
          pkt_end = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) pkt_end = 1'b1;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (pkt_end) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        pkt_d    = fifo_dout;
        state_d  = S_HDR;
      end else begin
        state_d  = S_IDLE;
      end
    end
  end

  always_comb begin
    link_d = LINK_IDLE;
    case (state_d)
      S_HDR:   link_d = rsp_hdr(pkt_d.is_write, pkt_d.err, pkt_d.code);
      S_RID:   link_d = {1'b0, pkt_d.src_id};
      S_DATA:  link_d = {1'b0, 8'(pkt_d.data >> {cnt_d, 3'b000})};
      default: link_d = LINK_IDLE;
    endcase
  end

  assign ALE_WRITE = link_q[8];
  assign CMD_WRITE = link_q[7:0];
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_noc_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_resp_serializer
// Description : Directed and random stimulus against a packet-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_resp_serializer;

  localparam int FIFO_DEPTH = 4;
  localparam int DATA_BYTES = 4;
  localparam logic [8:0] IDLE_W = 9'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic [7:0]  req_src_id;
  logic        req_err;
  logic [2:0]  req_err_code;
  logic [31:0] req_rd_data;
  logic [7:0]  CMD_WRITE;
  logic        ALE_WRITE;
  logic        busy;

  always #5 clk = ~clk;

  noc_resp_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_BYTES (DATA_BYTES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_write (req_is_write),
    .req_src_id   (req_src_id),
    .req_err      (req_err),
    .req_err_code (req_err_code),
    .req_rd_data  (req_rd_data),
    .CMD_WRITE    (CMD_WRITE),
    .ALE_WRITE    (ALE_WRITE),
    .busy         (busy)
  );

  typedef struct {
    logic        w;
    logic [7:0]  src;
    logic        err;
    logic [2:0]  code;
    logic [31:0] data;
  } cpl_t;

  cpl_t       pending[$];
  logic [8:0] cur[$];
  logic [8:0] shown;
  int         checks = 0;
  int         errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cpl_t mk(input logic w, input logic [7:0] src, input logic err,
                              input logic [2:0] code, input logic [31:0] data);
    cpl_t c;
    c.w = w; c.src = src; c.err = err; c.code = code; c.data = data;
    return c;
  endfunction

  // Expand one completion into the list of link words it must produce.
  task automatic load_packet(input cpl_t c);
    logic [7:0] hdr;
    hdr = {(c.w ? 3'b100 : 3'b010), 1'b0, c.err, (c.err ? c.code : 3'b000)};
    cur.push_back({1'b1, hdr});
    cur.push_back({1'b0, c.src});
    if (!c.w && !c.err)
      for (int i = DATA_BYTES - 1; i >= 0; i--) cur.push_back({1'b0, c.data[8*i +: 8]});
  endtask

  task automatic cycle(input logic r, input logic v, input cpl_t c, output logic acc);
    logic exp_ready;
    cpl_t head;
    rst          = r;
    req_valid    = v;
    req_is_write = c.w;
    req_src_id   = c.src;
    req_err      = c.err;
    req_err_code = c.code;
    req_rd_data  = c.data;
    #1;
    exp_ready = !r && (pending.size() < FIFO_DEPTH);
    chk_eq("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    acc = v && exp_ready;
    @(posedge clk);
    if (r) begin
      pending.delete();
      cur.delete();
      shown = IDLE_W;
    end else begin
      if (cur.size() != 0) begin
        shown = cur.pop_front();
      end else if (pending.size() != 0) begin
        head = pending.pop_front();
        load_packet(head);
        shown = cur.pop_front();
      end else begin
        shown = IDLE_W;
      end
      if (acc) pending.push_back(c);
    end
    #1;
    chk_eq("link", {23'b0, ALE_WRITE, CMD_WRITE}, {23'b0, shown});
    chk_eq("busy", {31'b0, busy}, {31'b0, (shown != IDLE_W) || (pending.size() != 0)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, mk(1'b0, 8'h00, 1'b0, 3'b000, 32'h0), acc);
  endtask

  task automatic send(input cpl_t c);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) cycle(1'b0, 1'b1, c, acc);
    if (!acc) chk_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic acc;
    cpl_t c;
    cycle(1'b1, 1'b0, mk(1'b0, 8'h00, 1'b0, 3'b000, 32'h0), acc);
    cycle(1'b1, 1'b1, mk(1'b1, 8'h99, 1'b0, 3'b000, 32'h0), acc);
    idle(2);

    send(mk(1'b0, 8'h5A, 1'b0, 3'd0, 32'hDEADBEEF));
    idle(8);
    send(mk(1'b1, 8'h11, 1'b0, 3'd0, 32'h0));
    send(mk(1'b1, 8'h22, 1'b1, 3'd5, 32'h0));
    idle(6);
    send(mk(1'b0, 8'h33, 1'b1, 3'd3, 32'hCAFEF00D));
    idle(4);
    send(mk(1'b0, 8'h44, 1'b0, 3'd7, 32'h01234567));
    idle(8);

    for (int i = 0; i < 5; i++) send(mk(1'b0, 8'hA0 + 8'(i), 1'b0, 3'd0, $urandom));
    idle(40);

    send(mk(1'b0, 8'h66, 1'b0, 3'd0, 32'h01020304));
    idle(3);
    cycle(1'b1, 1'b0, mk(1'b0, 8'h00, 1'b0, 3'b000, 32'h0), acc);
    send(mk(1'b1, 8'h7E, 1'b0, 3'd0, 32'h0));
    idle(4);

    for (int i = 0; i < 9; i++) send(mk(1'(i % 2), 8'(i), 1'(i == 4), 3'(i), $urandom));
    idle(40);

    for (int i = 0; i < 600; i++) begin
      c = mk(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
             3'($urandom), $urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), c, acc);
    end
    idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
